// File: rtl/locksys_pkg.sv
// Shared types and sizing for the PIN lock controller.
// State encoding and counter widths used by the top and its helpers.
package locksys_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ALARM = 2'd2
    } state_t;

    localparam int PIN_W_DEF = 16;
    localparam int FAIL_W    = 2;
    localparam int GRANT_W   = 8;

endpackage

// File: rtl/locksys_rise_det.sv
// Synchronous rising-edge detector for the enter strobe.
// One flop of history; rise is high on the first cycle d is seen high.
module locksys_rise_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    // remember last cycle's level of d
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/locksys.sv
// PIN lock controller: grants access on a matching PIN, latches
// alarm after consecutive failures until reset.
module locksys
    import locksys_pkg::*;
#(
    parameter int PIN_W        = PIN_W_DEF,
    parameter int MAX_TRIES    = 3,
    parameter int GRANT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PIN_W-1:0] setpin,
    input  logic [PIN_W-1:0] inpin,
    input  logic             enter,
    output logic             access,
    output logic             alarm
);

    state_t             state;
    state_t             state_d;
    logic [FAIL_W-1:0]  fail_cnt;
    logic [FAIL_W-1:0]  fail_d;
    logic [GRANT_W-1:0] grant_cnt;
    logic [GRANT_W-1:0] grant_d;
    logic               access_d;
    logic               alarm_d;
    logic               attempt;
    logic               match;
    logic               last_try;

    locksys_rise_det u_rise (
        .clk   (clk),
        .reset (reset),
        .d     (enter),
        .rise  (attempt)
    );

    assign match    = (inpin == setpin);
    assign last_try = (int'(fail_cnt) + 1) >= MAX_TRIES;

    // state, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            fail_cnt  <= '0;
            grant_cnt <= '0;
            access    <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            state     <= state_d;
            fail_cnt  <= fail_d;
            grant_cnt <= grant_d;
            access    <= access_d;
            alarm     <= alarm_d;
        end
    end

    // next state; attempts only count while idle
    always_comb begin
        state_d = state;
        fail_d  = fail_cnt;
        grant_d = grant_cnt;
        unique case (state)
            IDLE: begin
                if (attempt) begin
                    if (match) begin
                        state_d = GRANT;
                        fail_d  = '0;
                        grant_d = GRANT_W'(GRANT_CYCLES - 1);
                    end else if (last_try) begin
                        state_d = ALARM;
                    end else begin
                        fail_d = fail_cnt + 1'b1;
                    end
                end
            end
            GRANT: begin
                if (grant_cnt == '0) begin
                    state_d = IDLE;
                end else begin
                    grant_d = grant_cnt - 1'b1;
                end
            end
            ALARM: begin
                state_d = ALARM;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // outputs follow the state being entered, so they are mutually exclusive
    always_comb begin
        access_d = (state_d == GRANT);
        alarm_d  = (state_d == ALARM);
    end

endmodule

// File: tb/tb_locksys.sv
// Scoreboard bench for locksys: stimulus queues expected outputs,
// a monitor pops one entry per clock and compares.
module tb_locksys;

    localparam logic [15:0] OK  = 16'h1234;
    localparam logic [15:0] BAD = 16'h1235;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] setpin;
    logic [15:0] inpin;
    logic        enter;
    logic        access;
    logic        alarm;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_q[$];
    string      name_q[$];

    locksys dut (
        .clk    (clk),
        .reset  (reset),
        .setpin (setpin),
        .inpin  (inpin),
        .enter  (enter),
        .access (access),
        .alarm  (alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [1:0] act,
                       input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: access/alarm got %b required %b",
                     name, act, exp);
        end
    endtask

    // monitor: outputs settle after each posedge
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                chk(name_q.pop_front(), {access, alarm}, exp_q.pop_front());
            end
        end
    end

    // drive one cycle starting at a negedge; expectation is for the next posedge
    task automatic step(input logic en, input logic [15:0] pin,
                        input logic ea, input logic eal, input string name);
        enter = en;
        inpin = pin;
        exp_q.push_back({ea, eal});
        name_q.push_back(name);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input string name);
        reset = 1'b0;
        #1;
        chk(name, {access, alarm}, 2'b00);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset  = 1'b0;
        setpin = OK;
        inpin  = OK;
        enter  = 1'b1;
        @(negedge clk);
        chk("reset_state", {access, alarm}, 2'b00);
        reset = 1'b1;

        // 1: enter high across release, correct PIN
        for (int i = 0; i < 4; i++) step(1, OK, 1, 0, "t1_grant");
        step(1, OK, 0, 0, "t1_end");
        step(0, OK, 0, 0, "t1_idle");

        // 3: two wrong, one right, then two wrong again
        for (int i = 0; i < 2; i++) begin
            step(1, BAD, 0, 0, "t3_wrong");
            step(0, BAD, 0, 0, "t3_wrong_lo");
        end
        step(1, OK, 1, 0, "t3_grant");
        for (int i = 0; i < 3; i++) step(0, OK, 1, 0, "t3_grant");
        step(0, OK, 0, 0, "t3_end");
        for (int i = 0; i < 2; i++) begin
            step(1, BAD, 0, 0, "t3_wrong2");
            step(0, BAD, 0, 0, "t3_wrong2_lo");
        end
        step(1, OK, 1, 0, "t3_clear");
        for (int i = 0; i < 3; i++) step(0, OK, 1, 0, "t3_clear");
        step(0, OK, 0, 0, "t3_clear_end");

        // 2: three wrong attempts latch alarm
        for (int i = 0; i < 2; i++) begin
            step(1, BAD, 0, 0, "t2_wrong");
            step(0, BAD, 0, 0, "t2_wrong_lo");
        end
        step(1, BAD, 0, 1, "t2_alarm");
        step(0, BAD, 0, 1, "t2_alarm_hold");

        // 4: correct PIN ignored in alarm; async reset clears
        step(1, OK, 0, 1, "t4_ignored");
        step(0, OK, 0, 1, "t4_ignored");
        step(0, OK, 0, 1, "t4_ignored");
        do_reset("t4_async_rst");

        // 5: held enter is one attempt; two more wrong reach alarm
        for (int i = 0; i < 10; i++) step(1, BAD, 0, 0, "t5_hold");
        step(0, BAD, 0, 0, "t5_drop");
        step(1, BAD, 0, 0, "t5_second");
        step(0, BAD, 0, 0, "t5_second_lo");
        step(1, BAD, 0, 1, "t5_third");
        step(0, BAD, 0, 1, "t5_third_lo");
        do_reset("t5_rst");

        // 6: reset mid-grant, then re-edge inside window is dropped
        step(1, OK, 1, 0, "t6_grant");
        step(0, OK, 1, 0, "t6_grant");
        do_reset("t6_mid_grant_rst");
        step(1, OK, 1, 0, "t6_regrant");
        step(0, OK, 1, 0, "t6_regrant");
        step(1, OK, 1, 0, "t6_edge_in_grant");
        step(0, OK, 1, 0, "t6_regrant");
        step(0, OK, 0, 0, "t6_end");
        step(0, OK, 0, 0, "t6_not_queued");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
